// File: rtl/width_upsizer_pkg.sv
// Types and helpers shared by the width_upsizer slice.
package width_upsizer_pkg;
`include "gearbox_defs.vh"

  typedef enum logic {PK_EMPTY, PK_FILL} pack_state_e;
  typedef enum logic {OEMPTY, OFULL} out_state_e;
endpackage

// File: rtl/gearbox_defs.vh
// Shared width macros and lane-mapping helper for the gearbox family (upsizer/downsizer).
`ifndef GEARBOX_DEFS_VH
`define GEARBOX_DEFS_VH

`define GB_OUT_W(iw, r) ((iw) * (r))
`define GB_CNT_W(r) (((r) > 1) ? $clog2(r) : 1)

// Beat number within a word -> physical lane, honouring the first-beat placement.
function automatic int gb_lane_idx(input int cnt, input int ratio, input bit lsb_first);
  return lsb_first ? cnt : (ratio - 1 - cnt);
endfunction

`endif

// File: rtl/gearbox_out_reg.sv
// One-deep valid/ready output register carrying an opaque payload.
module gearbox_out_reg
  import width_upsizer_pkg::*;
#(
  parameter int PAYLOAD_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_payload
);

  out_state_e state_q, state_d;
  logic       load;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= OEMPTY;
      out_payload <= '0;
    end else begin
      state_q <= state_d;
      if (load) out_payload <= in_payload;
    end
  end

  // A load in the same cycle as a downstream accept keeps the register full.
  always_comb begin
    state_d  = state_q;
    in_ready = !rst && ((state_q == OEMPTY) || out_ready);
    load     = in_valid && in_ready;
    case (state_q)
      OEMPTY:  if (load) state_d = OFULL;
      OFULL:   if (!load && out_ready) state_d = OEMPTY;
      default: state_d = OEMPTY;
    endcase
  end

  assign out_valid = (state_q == OFULL);

endmodule

// File: rtl/width_upsizer.sv
// Narrow-to-wide gearbox: packs RATIO input beats into one wide word with lane keep.
`include "gearbox_defs.vh"

module width_upsizer
  import width_upsizer_pkg::*;
#(
  parameter int IN_WIDTH  = 8,
  parameter int RATIO     = 2,
  parameter int LSB_FIRST = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [IN_WIDTH-1:0]           in_data,
  input  logic                          in_last,
  input  logic                          flush,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [`GB_OUT_W(IN_WIDTH, RATIO)-1:0] out_data,
  output logic [RATIO-1:0]              out_keep,
  output logic                          out_last
);

  localparam int OUT_W = `GB_OUT_W(IN_WIDTH, RATIO);
  localparam int CNT_W = `GB_CNT_W(RATIO);
  localparam int PAY_W = OUT_W + RATIO + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RATIO - 1);

  logic [OUT_W-1:0] buf_q, data_m;
  logic [RATIO-1:0] keep_q, keep_m;
  logic [CNT_W-1:0] cnt_q;
  logic             flush_pend_q;
  logic             acc, flush_req, complete;
  int               lane;
  pack_state_e      pack_st;

  always_comb begin
    acc       = in_valid && in_ready;
    flush_req = flush || flush_pend_q;
    pack_st   = (cnt_q == '0) ? PK_EMPTY : PK_FILL;
    lane      = gb_lane_idx(int'(cnt_q), RATIO, LSB_FIRST != 0);
    // Unfilled lanes of buf_q are always zero, so merging is a plain OR.
    data_m    = buf_q | (acc ? (OUT_W'(in_data) << (lane * IN_WIDTH)) : '0);
    keep_m    = keep_q | (acc ? (RATIO'(1) << lane) : '0);
    complete  = (acc && ((cnt_q == CNT_MAX) || in_last))
             || (in_ready && flush_req && ((pack_st == PK_FILL) || acc));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q        <= '0;
      keep_q       <= '0;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      // A flush seen while the output is stalled waits for the register to free up.
      if (in_ready)   flush_pend_q <= 1'b0;
      else if (flush) flush_pend_q <= 1'b1;

      if (complete) begin
        buf_q  <= '0;
        keep_q <= '0;
        cnt_q  <= '0;
      end else if (acc) begin
        buf_q  <= data_m;
        keep_q <= keep_m;
        cnt_q  <= cnt_q + CNT_W'(1);
      end
    end
  end

  logic [PAY_W-1:0] pay_in, pay_out;

  assign pay_in = {acc && in_last, keep_m, data_m};

  gearbox_out_reg #(
    .PAYLOAD_W (PAY_W)
  ) u_out_reg (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (complete),
    .in_ready    (in_ready),
    .in_payload  (pay_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_payload (pay_out)
  );

  assign out_data = pay_out[OUT_W-1:0];
  assign out_keep = pay_out[OUT_W +: RATIO];
  assign out_last = pay_out[PAY_W-1];

endmodule

// File: tb/tb_width_upsizer.sv
// Directed bench for width_upsizer: default, defparam-resized and MSB-first instances.
module tb_width_upsizer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   checks   = 0;
  int   failures = 0;

  // Default instance: IN_WIDTH=8, RATIO=2, LSB_FIRST=1
  logic        a_in_valid, a_in_ready, a_in_last, a_flush;
  logic        a_out_valid, a_out_ready, a_out_last;
  logic [7:0]  a_in_data;
  logic [15:0] a_out_data;
  logic [1:0]  a_out_keep;

  // defparam instance: IN_WIDTH=4, RATIO=4
  logic        u_in_valid, u_in_ready, u_in_last, u_flush;
  logic        u_out_valid, u_out_ready, u_out_last;
  logic [3:0]  u_in_data;
  logic [15:0] u_out_data;
  logic [3:0]  u_out_keep;

  // #() instance: IN_WIDTH=8, RATIO=2, LSB_FIRST=0
  logic        l_in_valid, l_in_ready, l_in_last, l_flush;
  logic        l_out_valid, l_out_ready, l_out_last;
  logic [7:0]  l_in_data;
  logic [15:0] l_out_data;
  logic [1:0]  l_out_keep;

  width_upsizer ua (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .in_last(a_in_last), .flush(a_flush),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_keep(a_out_keep), .out_last(a_out_last)
  );

  width_upsizer u (
    .clk(clk), .rst(rst), .in_valid(u_in_valid), .in_ready(u_in_ready),
    .in_data(u_in_data), .in_last(u_in_last), .flush(u_flush),
    .out_valid(u_out_valid), .out_ready(u_out_ready), .out_data(u_out_data),
    .out_keep(u_out_keep), .out_last(u_out_last)
  );
  defparam u.IN_WIDTH = 4;
  defparam u.RATIO = 4;

  width_upsizer #(.IN_WIDTH(8), .RATIO(2), .LSB_FIRST(0)) ul (
    .clk(clk), .rst(rst), .in_valid(l_in_valid), .in_ready(l_in_ready),
    .in_data(l_in_data), .in_last(l_in_last), .flush(l_flush),
    .out_valid(l_out_valid), .out_ready(l_out_ready), .out_data(l_out_data),
    .out_keep(l_out_keep), .out_last(l_out_last)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    a_in_valid = 0; a_in_last = 0; a_flush = 0; a_out_ready = 1; a_in_data = '0;
    u_in_valid = 0; u_in_last = 0; u_flush = 0; u_out_ready = 1; u_in_data = '0;
    l_in_valid = 0; l_in_last = 0; l_flush = 0; l_out_ready = 1; l_in_data = '0;
    #1;
    chk("rst_in_ready", a_in_ready, 0);
    tick();
    tick();
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_out_data", a_out_data, 16'h0000);
    chk("rst_out_keep", a_out_keep, 2'b00);
    chk("rst_out_last", a_out_last, 0);
    chk("rst_u_out_valid", u_out_valid, 0);
    chk("rst_l_out_valid", l_out_valid, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", a_in_ready, 1);

    // Full word, LSB first
    a_in_valid = 1; a_in_data = 8'hA1;
    tick();
    chk("w1_half_valid", a_out_valid, 0);
    a_in_data = 8'hB2;
    tick();
    chk("w1_valid", a_out_valid, 1);
    chk("w1_data", a_out_data, 16'hB2A1);
    chk("w1_keep", a_out_keep, 2'b11);
    chk("w1_last", a_out_last, 0);
    a_in_valid = 0;
    tick();
    chk("w1_drain", a_out_valid, 0);

    // Partial word closed by in_last
    a_in_valid = 1; a_in_data = 8'h5C; a_in_last = 1;
    tick();
    chk("last_valid", a_out_valid, 1);
    chk("last_data", a_out_data, 16'h005C);
    chk("last_keep", a_out_keep, 2'b01);
    chk("last_last", a_out_last, 1);
    a_in_valid = 0; a_in_last = 0;
    tick();
    chk("last_drain", a_out_valid, 0);

    // Backpressure: word held, offered beat C3 must not be taken
    a_out_ready = 0; a_in_valid = 1; a_in_data = 8'hA1;
    tick();
    a_in_data = 8'hB2;
    tick();
    chk("bp_valid", a_out_valid, 1);
    a_in_data = 8'hC3;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_data", a_out_data, 16'hB2A1);
      chk("bp_in_ready", a_in_ready, 0);
      chk("bp_hold_valid", a_out_valid, 1);
    end
    a_in_valid = 0; a_out_ready = 1;
    #1;
    chk("bp_release_in_ready", a_in_ready, 1);
    tick();
    chk("bp_release_valid", a_out_valid, 0);
    a_in_valid = 1; a_in_data = 8'hD4; a_in_last = 1;
    tick();
    chk("bp_no_stray_data", a_out_data, 16'h00D4);
    chk("bp_no_stray_keep", a_out_keep, 2'b01);
    a_in_valid = 0; a_in_last = 0;
    tick();

    // Flush of a partial word, then flush with nothing buffered
    a_in_valid = 1; a_in_data = 8'h3C;
    tick();
    a_in_valid = 0; a_flush = 1;
    tick();
    chk("flush_valid", a_out_valid, 1);
    chk("flush_data", a_out_data, 16'h003C);
    chk("flush_keep", a_out_keep, 2'b01);
    chk("flush_last", a_out_last, 0);
    a_flush = 0;
    tick();
    chk("flush_drain", a_out_valid, 0);
    a_flush = 1;
    tick();
    a_flush = 0;
    chk("flush_empty_noop", a_out_valid, 0);

    // Flush during a stall stays pending; the next beat is emitted alone with no bubble
    a_out_ready = 0; a_in_valid = 1; a_in_data = 8'h01; a_in_last = 1;
    tick();
    a_in_valid = 0; a_in_last = 0; a_flush = 1;
    tick();
    chk("pend_hold_data", a_out_data, 16'h0001);
    a_flush = 0;
    tick();
    chk("pend_hold_valid", a_out_valid, 1);
    a_out_ready = 1; a_in_valid = 1; a_in_data = 8'h42;
    tick();
    chk("pend_valid", a_out_valid, 1);
    chk("pend_data", a_out_data, 16'h0042);
    chk("pend_keep", a_out_keep, 2'b01);
    chk("pend_last", a_out_last, 0);
    a_in_valid = 0;
    tick();
    chk("pend_drain", a_out_valid, 0);

    // Reset mid-word discards the buffered beat
    a_in_valid = 1; a_in_data = 8'h77;
    tick();
    a_in_valid = 0; rst = 1;
    tick();
    chk("rmw_valid", a_out_valid, 0);
    rst = 0; a_in_valid = 1; a_in_data = 8'h01;
    tick();
    a_in_data = 8'h02;
    tick();
    chk("rmw_data", a_out_data, 16'h0201);
    chk("rmw_keep", a_out_keep, 2'b11);
    a_in_valid = 0;
    tick();

    // Reset mid-stall discards the pending word
    a_out_ready = 0; a_in_valid = 1; a_in_data = 8'h88; a_in_last = 1;
    tick();
    chk("rms_stalled", a_out_valid, 1);
    a_in_valid = 0; a_in_last = 0; rst = 1;
    tick();
    chk("rms_valid", a_out_valid, 0);
    chk("rms_data", a_out_data, 16'h0000);
    rst = 0; a_out_ready = 1;
    tick();
    chk("rms_after", a_out_valid, 0);

    // defparam instance: four nibbles
    u_in_valid = 1; u_in_data = 4'h1;
    tick();
    u_in_data = 4'h2;
    tick();
    u_in_data = 4'h3;
    tick();
    chk("u_partial_valid", u_out_valid, 0);
    u_in_data = 4'h4;
    tick();
    chk("u_valid", u_out_valid, 1);
    chk("u_data", u_out_data, 16'h4321);
    chk("u_keep", u_out_keep, 4'hF);
    u_in_valid = 0;
    tick();

    // MSB-first instance
    l_in_valid = 1; l_in_data = 8'h11;
    tick();
    l_in_data = 8'h22;
    tick();
    chk("l_data", l_out_data, 16'h1122);
    chk("l_keep", l_out_keep, 2'b11);
    l_in_data = 8'h33;
    tick();
    l_in_valid = 0; l_flush = 1;
    tick();
    chk("l_flush_valid", l_out_valid, 1);
    chk("l_flush_data", l_out_data, 16'h3300);
    chk("l_flush_keep", l_out_keep, 2'b10);
    chk("l_flush_last", l_out_last, 0);
    l_flush = 0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
